// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
//   BYP_RF          : bypass select meaning "read the register file"
//   ENT_*_OFS       : flag offsets of a tracking entry, counted from the bit above rd.
//                     Entry layout is {valid, wen, is_load, rd}.
//   NOP_INSN        : NOP instruction word used by the processor's bubble/flush muxes
//   haz_cause_e     : the single reason the decode stage is being held or cleared this cycle
//   byp_code()      : maps the index of the youngest matching entry to a bypass select
package pipe_hazard_ctrl_pkg;

  localparam int unsigned BYP_RF        = 32'd0;
  localparam int unsigned ENT_LOAD_OFS  = 32'd0;
  localparam int unsigned ENT_WEN_OFS   = 32'd1;
  localparam int unsigned ENT_VALID_OFS = 32'd2;
  localparam int unsigned ENT_FLAG_W    = 32'd3;
  localparam logic [31:0] NOP_INSN      = 32'h0000_0013;

  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_DATA     = 2'd1,
    HZ_MD       = 2'd2,
    HZ_REDIRECT = 2'd3
  } haz_cause_e;

  // The oldest entry has already written the regfile by the time decode reads it,
  // so it needs no bypass. Younger entries forward from stage (idx + 1), i.e. select idx + 2.
  function automatic int unsigned byp_code(input int unsigned idx, input int unsigned num_stages);
    int unsigned code;
    if (idx == num_stages - 32'd1) begin
      code = BYP_RF;
    end else if (idx + 32'd2 > num_stages) begin
      code = num_stages;
    end else begin
      code = idx + 32'd2;
    end
    return code;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_seq.sv
// md_seq_counter: sequences the multicycle mult/div unit.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset; abandons any operation in flight
//   start : one-cycle launch pulse
//   busy  : high while the countdown is non-zero (MD_LATENCY-1 cycles)
//   done  : one-cycle pulse, MD_LATENCY cycles after start
module md_seq_counter #(
  parameter int MD_LATENCY = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r;
  logic             done_r;

  // Countdown register; done is registered off the 1 -> 0 step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r  <= CNT_ZERO;
      done_r <= 1'b0;
    end else begin
      if (start) begin
        cnt_r <= CNT_LOAD;
      end else if (cnt_r != CNT_ZERO) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      done_r <= (cnt_r == CNT_ONE) & ~start;
    end
  end

  assign busy = (cnt_r != CNT_ZERO);
  assign done = done_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, interlock and bypass controller beside the decode stage.
// Tracks each in-flight destination in a NUM_STAGES-deep valid/rd shift register
// (entry 0 = execute) and produces:
//   stall_fd / bubble_dx / flush_fd : combinational pipeline controls
//   byp_a_sel / byp_b_sel           : registered operand bypass selects (0 = regfile,
//                                     k = result of stage k-1)
//   md_start / md_busy / md_done    : mult/div sequencing
//   stage_valid                     : valid bit per tracked entry
// Inputs: clock, reset (async, active-low), id_* decode fields, x_br_taken redirect.
// Build option: define HAZ_CTRL_BYPASS_EN to enable operand forwarding. Without it the
// selects stay 0 and any match younger than the oldest entry interlocks instead.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 32,
  localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_AW-1:0]     id_rd,
  input  logic                  id_wen,
  input  logic                  id_is_load,
  input  logic                  id_is_md,
  input  logic                  x_br_taken,
  output logic                  stall_fd,
  output logic                  bubble_dx,
  output logic                  flush_fd,
  output logic [SEL_W-1:0]      byp_a_sel,
  output logic [SEL_W-1:0]      byp_b_sel,
  output logic                  md_start,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [NUM_STAGES-1:0] stage_valid
);

  localparam int ENT_W   = REG_AW + int'(ENT_FLAG_W);
  localparam int RD_MSB  = REG_AW - 1;
  localparam int LOAD_B  = REG_AW + int'(ENT_LOAD_OFS);
  localparam int WEN_B   = REG_AW + int'(ENT_WEN_OFS);
  localparam int VALID_B = REG_AW + int'(ENT_VALID_OFS);

  logic [ENT_W-1:0]      entry_r [NUM_STAGES];
  logic [NUM_STAGES-1:0] hit_a_s;
  logic [NUM_STAGES-1:0] hit_b_s;
  logic                  load_use_s;
  logic                  data_haz_s;
  logic                  md_hold_s;
  logic                  md_busy_s;
  logic                  md_done_s;
  logic                  md_start_s;
  logic                  advance_s;
  logic                  stall_s;
  logic                  bubble_s;
  logic                  flush_s;
  logic [NUM_STAGES-1:0] stage_valid_s;
  haz_cause_e            cause_s;

  // Compare both decode sources against every tracked destination (r0 never matches).
  always_comb begin
    hit_a_s = {NUM_STAGES{1'b0}};
    hit_b_s = {NUM_STAGES{1'b0}};
    for (int k = 0; k < NUM_STAGES; k++) begin
      hit_a_s[k] = entry_r[k][VALID_B] & entry_r[k][WEN_B] & (|entry_r[k][RD_MSB:0])
                 & id_rs1_used & (entry_r[k][RD_MSB:0] == id_rs1);
      hit_b_s[k] = entry_r[k][VALID_B] & entry_r[k][WEN_B] & (|entry_r[k][RD_MSB:0])
                 & id_rs2_used & (entry_r[k][RD_MSB:0] == id_rs2);
    end
  end

  // A load in execute cannot forward yet: its data appears only after M.
  assign load_use_s = entry_r[0][LOAD_B] & (hit_a_s[0] | hit_b_s[0]);

`ifdef HAZ_CTRL_BYPASS_EN
  assign data_haz_s = load_use_s;
`else
  // Without forwarding, wait until the producer sits in the oldest entry.
  localparam logic [NUM_STAGES-1:0] YOUNG_MASK = {1'b0, {(NUM_STAGES-1){1'b1}}};
  assign data_haz_s = load_use_s | (|((hit_a_s | hit_b_s) & YOUNG_MASK));
`endif

  // md_done's cycle still holds decode; issue resumes the cycle after.
  assign md_hold_s = md_busy_s | md_done_s;

  // Pick the one reason decode is affected; a redirect overrides any stall.
  always_comb begin
    if (!reset) begin
      cause_s = HZ_NONE;
    end else if (x_br_taken) begin
      cause_s = HZ_REDIRECT;
    end else if (id_valid & md_hold_s) begin
      cause_s = HZ_MD;
    end else if (id_valid & data_haz_s) begin
      cause_s = HZ_DATA;
    end else begin
      cause_s = HZ_NONE;
    end
  end

  // Translate the cause into the pipeline control lines.
  always_comb begin
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    flush_s  = 1'b0;
    case (cause_s)
      HZ_REDIRECT: begin
        flush_s  = 1'b1;
        bubble_s = 1'b1;
      end
      HZ_MD, HZ_DATA: begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
      end
      default: begin
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        flush_s  = 1'b0;
      end
    endcase
  end

  assign advance_s  = id_valid & ~stall_s;
  assign md_start_s = reset & advance_s & id_is_md & ~x_br_taken;

  // Destination tracking shift register; the pipe below decode always drains.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        entry_r[k] <= {ENT_W{1'b0}};
      end
    end else begin
      if (advance_s & ~x_br_taken) begin
        entry_r[0] <= {1'b1, id_wen, id_is_load, id_rd};
      end else begin
        entry_r[0] <= {ENT_W{1'b0}};
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        entry_r[k] <= entry_r[k-1];
      end
    end
  end

`ifdef HAZ_CTRL_BYPASS_EN
  logic [SEL_W-1:0] sel_a_s;
  logic [SEL_W-1:0] sel_b_s;
  logic [SEL_W-1:0] sel_a_r;
  logic [SEL_W-1:0] sel_b_r;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel_a_s = SEL_W'(BYP_RF);
    sel_b_s = SEL_W'(BYP_RF);
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      sel_a_s = hit_a_s[k] ? SEL_W'(byp_code(unsigned'(k), NUM_STAGES)) : sel_a_s;
      sel_b_s = hit_b_s[k] ? SEL_W'(byp_code(unsigned'(k), NUM_STAGES)) : sel_b_s;
    end
  end

  // Selects follow the instruction into execute; anything else falls back to the regfile.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_a_r <= {SEL_W{1'b0}};
      sel_b_r <= {SEL_W{1'b0}};
    end else if (advance_s) begin
      sel_a_r <= sel_a_s;
      sel_b_r <= sel_b_s;
    end else begin
      sel_a_r <= {SEL_W{1'b0}};
      sel_b_r <= {SEL_W{1'b0}};
    end
  end

  assign byp_a_sel = sel_a_r;
  assign byp_b_sel = sel_b_r;
`else
  assign byp_a_sel = {SEL_W{1'b0}};
  assign byp_b_sel = {SEL_W{1'b0}};
`endif

  // Expose each entry's valid bit.
  always_comb begin
    stage_valid_s = {NUM_STAGES{1'b0}};
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_valid_s[k] = entry_r[k][VALID_B];
    end
  end

  md_seq_counter #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_seq (
    .clock (clock),
    .reset (reset),
    .start (md_start_s),
    .busy  (md_busy_s),
    .done  (md_done_s)
  );

  assign stall_fd    = stall_s;
  assign bubble_dx   = bubble_s;
  assign flush_fd    = flush_s;
  assign md_start    = md_start_s;
  assign md_busy     = md_busy_s;
  assign md_done     = md_done_s;
  assign stage_valid = stage_valid_s;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (NUM_STAGES=3, REG_AW=5, MD_LATENCY=32).
// A reference model tracks in-flight instructions as records and mult/div timing
// by cycle numbers; directed program snippets run first, then randomized traffic.
module tb_pipe_hazard_ctrl;

  localparam int NS  = 3;
  localparam int AW  = 5;
  localparam int LAT = 32;
  localparam int SW  = $clog2(NS + 1);
`ifdef HAZ_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          id_valid, id_rs1_used, id_rs2_used, id_wen, id_is_load, id_is_md, x_br_taken;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          stall_fd, bubble_dx, flush_fd, md_start, md_busy, md_done;
  logic [SW-1:0] byp_a_sel, byp_b_sel;
  logic [NS-1:0] stage_valid;

  pipe_hazard_ctrl #(.NUM_STAGES(NS), .REG_AW(AW), .MD_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .id_is_md(id_is_md), .x_br_taken(x_br_taken),
    .stall_fd(stall_fd), .bubble_dx(bubble_dx), .flush_fd(flush_fd),
    .byp_a_sel(byp_a_sel), .byp_b_sel(byp_b_sel), .md_start(md_start), .md_busy(md_busy),
    .md_done(md_done), .stage_valid(stage_valid));

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {logic v; logic w; logic ld; logic [AW-1:0] rd;} ent_t;
  ent_t          pipe [NS];
  int            cyc = 0;
  bit            md_active = 1'b0;
  int            md_t0 = 0;
  logic [SW-1:0] sel_a_q = '0, sel_b_q = '0;
  bit            e_stall, e_bubble, e_flush, e_start, e_busy, e_done, e_adv;
  logic [SW-1:0] e_sa, e_sb;

  // observations from the latest step, used by directed checks
  bit            last_stall, last_flush;
  logic [SW-1:0] last_sa, last_sb;
  logic [NS-1:0] last_sv;
  int            cnt_busy = 0, cnt_done = 0, cnt_start = 0;

  function automatic bit hits(int k, logic [AW-1:0] rs, logic used);
    return pipe[k].v && pipe[k].w && (pipe[k].rd != 0) && (pipe[k].rd == rs) && used;
  endfunction

  function automatic int youngest(logic [AW-1:0] rs, logic used);
    for (int k = 0; k < NS; k++) if (hits(k, rs, used)) return k;
    return -1;
  endfunction

  function automatic logic [SW-1:0] sel_for(int k);
    if (k < 0 || k == NS - 1) return '0;
    return SW'((k + 2 > NS) ? NS : k + 2);
  endfunction

  function automatic logic [NS-1:0] exp_sv();
    logic [NS-1:0] r;
    for (int k = 0; k < NS; k++) r[k] = pipe[k].v;
    return r;
  endfunction

  function automatic logic [31:0] obs_all();
    return 32'({stall_fd, bubble_dx, flush_fd, md_start, md_busy, md_done,
                byp_a_sel, byp_b_sel, stage_valid});
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) pipe[k] = '0;
    sel_a_q = '0;
    sel_b_q = '0;
    md_active = 1'b0;
  endtask

  task automatic model_eval();
    int ya, yb;
    bit haz, want;
    ya = youngest(id_rs1, id_rs1_used);
    yb = youngest(id_rs2, id_rs2_used);
    if (BYP) haz = pipe[0].ld && (ya == 0 || yb == 0);
    else     haz = (ya >= 0 && ya < NS - 1) || (yb >= 0 && yb < NS - 1);
    e_busy   = md_active && (cyc > md_t0) && (cyc < md_t0 + LAT);
    e_done   = md_active && (cyc == md_t0 + LAT);
    want     = id_valid && (haz || e_busy || e_done);
    e_flush  = x_br_taken;
    e_stall  = want && !x_br_taken;
    e_bubble = want || x_br_taken;
    e_adv    = id_valid && !e_stall;
    e_start  = e_adv && id_is_md && !x_br_taken;
    e_sa     = BYP ? sel_for(ya) : '0;
    e_sb     = BYP ? sel_for(yb) : '0;
  endtask

  task automatic model_commit();
    for (int k = NS - 1; k > 0; k--) pipe[k] = pipe[k-1];
    if (e_adv && !x_br_taken) pipe[0] = '{v: 1'b1, w: id_wen, ld: id_is_load, rd: id_rd};
    else                      pipe[0] = '0;
    sel_a_q = e_adv ? e_sa : '0;
    sel_b_q = e_adv ? e_sb : '0;
    if (e_start) begin
      md_active = 1'b1;
      md_t0 = cyc;
    end
    cyc++;
  endtask

  // One clock: check on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clock);
    model_eval();
    last_stall = stall_fd;
    last_flush = flush_fd;
    last_sa    = byp_a_sel;
    last_sb    = byp_b_sel;
    last_sv    = stage_valid;
    if (md_busy)  cnt_busy++;
    if (md_done)  cnt_done++;
    if (md_start) cnt_start++;
    check_eq("ctl", 32'({stall_fd, bubble_dx, flush_fd, md_start, md_busy, md_done}),
             32'({e_stall, e_bubble, e_flush, e_start, e_busy, e_done}));
    check_eq("byp_a", 32'(byp_a_sel), 32'(sel_a_q));
    check_eq("byp_b", 32'(byp_b_sel), 32'(sel_b_q));
    check_eq("stage_valid", 32'(stage_valid), 32'(exp_sv()));
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    x_br_taken = 1'b0;
    repeat (n) step();
  endtask

  // Present one instruction in decode and hold it until it issues; returns stall count.
  task automatic issue(input int rs1, input bit u1, input int rs2, input bit u2, input int rd,
                       input bit wen, input bit ld, input bit md, output int stalls);
    bit went;
    went = 1'b0;
    stalls = 0;
    id_valid = 1'b1; id_rs1 = AW'(rs1); id_rs1_used = u1; id_rs2 = AW'(rs2); id_rs2_used = u2;
    id_rd = AW'(rd); id_wen = wen; id_is_load = ld; id_is_md = md; x_br_taken = 1'b0;
    for (int i = 0; i < 200 && !went; i++) begin
      step();
      if (last_stall) stalls++;
      else went = 1'b1;
    end
    if (!went) check_eq("issue_timeout", 32'(went), 32'd1);
    id_valid = 1'b0;
  endtask

  task automatic rand_insn();
    id_valid    = ($urandom_range(0, 9) < 8);
    id_rs1      = AW'($urandom_range(0, 4));
    id_rs2      = AW'($urandom_range(0, 4));
    id_rs1_used = ($urandom_range(0, 3) != 0);
    id_rs2_used = ($urandom_range(0, 3) != 0);
    id_rd       = AW'($urandom_range(0, 4));
    id_wen      = ($urandom_range(0, 4) != 0);
    id_is_load  = ($urandom_range(0, 3) == 0);
    id_is_md    = ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    // Reset state with busy-looking inputs: every output must still be 0.
    id_valid = 1'b1; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    id_rd = 5'd3; id_wen = 1'b1; id_is_load = 1'b1; id_is_md = 1'b1; x_br_taken = 1'b1;
    #3;
    check_eq("reset_outs", obs_all(), 32'd0);
    id_valid = 1'b0; x_br_taken = 1'b0; id_is_md = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
    idle(2);

    // add r3,r1,r2 ; add r4,r3,r3
    issue(1, 1, 2, 1, 3, 1, 0, 0, s);
    issue(3, 1, 3, 1, 4, 1, 0, 0, s);
    check_eq("t1_stalls", 32'(s), BYP ? 32'd0 : 32'd2);
    idle(1);
    check_eq("t1_sel_a", 32'(last_sa), BYP ? 32'd2 : 32'd0);
    check_eq("t1_sel_b", 32'(last_sb), BYP ? 32'd2 : 32'd0);
    idle(NS + 1);

    // lw r5,0(r0) ; add r6,r5,r1
    issue(0, 1, 0, 0, 5, 1, 1, 0, s);
    issue(5, 1, 1, 1, 6, 1, 0, 0, s);
    check_eq("t2_stalls", 32'(s), BYP ? 32'd1 : 32'd2);
    idle(1);
    check_eq("t2_sel_a", 32'(last_sa), BYP ? 32'd3 : 32'd0);
    idle(NS + 1);

    // add r0,r1,r2 ; add r7,r0,r0
    issue(1, 1, 2, 1, 0, 1, 0, 0, s);
    issue(0, 1, 0, 1, 7, 1, 0, 0, s);
    check_eq("t3_stalls", 32'(s), 32'd0);
    idle(1);
    check_eq("t3_sel_a", 32'(last_sa), 32'd0);
    idle(NS + 1);

    // mul r8,r1,r2 then three independent instructions
    cnt_busy = 0; cnt_done = 0; cnt_start = 0;
    issue(1, 1, 2, 1, 8, 1, 0, 1, s);
    issue(1, 1, 2, 1, 9, 1, 0, 0, s);
    check_eq("t4_stalls", 32'(s), 32'd32);
    check_eq("t4_busy_cycles", 32'(cnt_busy), 32'd31);
    check_eq("t4_done_pulses", 32'(cnt_done), 32'd1);
    check_eq("t4_start_pulses", 32'(cnt_start), 32'd1);
    issue(2, 1, 1, 1, 10, 1, 0, 0, s);
    issue(1, 1, 1, 0, 11, 1, 0, 0, s);
    check_eq("t4_after_stalls", 32'(s), 32'd0);
    idle(NS + 1);

    // load-use collides with a taken branch
    issue(0, 1, 0, 0, 5, 1, 1, 0, s);
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rs2 = 5'd1; id_rs2_used = 1'b1;
    id_rd = 5'd6; id_wen = 1'b1; id_is_load = 1'b0; id_is_md = 1'b0; x_br_taken = 1'b1;
    step();
    check_eq("t5_flush", 32'(last_flush), 32'd1);
    check_eq("t5_stall", 32'(last_stall), 32'd0);
    idle(1);
    check_eq("t5_entry0", 32'(last_sv[0]), 32'd0);
    idle(NS + 1);

    // reset in the middle of a mult/div
    issue(1, 1, 2, 1, 12, 1, 0, 1, s);
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd13; id_is_md = 1'b0;
    repeat (9) step();
    #2 reset = 1'b0;
    #1 check_eq("t6_async_clear", obs_all(), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      check_eq("t6_held_clear", obs_all(), 32'd0);
    end
    id_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
    idle(2);
    check_eq("t6_no_done", 32'(md_done), 32'd0);

    // randomized traffic; a stalled instruction stays in decode
    last_stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!last_stall) rand_insn();
      x_br_taken = ($urandom_range(0, 9) == 0);
      step();
    end
    idle(LAT + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
